char_buffer: RTL and testbench
==============================

// Module: char_buffer
// PURPOSE
// - Text-mode character store for the VGA console: 128 col x 32 row array of 8-bit ASCII codes.
// - CPU side writes characters and the scroll/cursor registers. VGA side reads one character per clock.
// - Applies the vertical scroll offset to every read and flags the blinking cursor cell.
// - Sits between the memory-mapped bus decode and the vga_ascii font renderer.
// PARAMETERS
// - COL_W   7   column index width (128 columns addressable, 70 displayed)
// - ROW_W   5   row index width (32 rows addressable, 30 displayed)
// - DATA_W  8   character code width
// PORTS
// - clk          in   1   sole clock, all state rises on posedge
// - reset_n      in   1   asynchronous, active-low reset
// - we           in   1   character write strobe
// - wr_addr      in   12  write address: [11:5] = column, [4:0] = absolute row
// - wr_data      in   8   character code to write
// - rd_col       in   7   column currently scanned by VGA
// - rd_row       in   5   screen row currently scanned by VGA
// - rd_data      out  8   character at scanned cell, registered
// - off_we       in   1   scroll-offset register write strobe
// - off_in       in   5   new scroll offset
// - line_offset  out  5   current scroll offset
// - cur_we       in   1   cursor register write strobe
// - cur_in       in   12  new cursor: [11:7] = row, [6:0] = column
// - cur_col      out  7   cursor column
// - cur_row      out  5   cursor row
// - blink        in   1   blink phase (1 = cursor visible)
// - cursor_on    out  1   scanned cell is the cursor and blink=1, registered
// BEHAVIOUR
// - Storage
//   - 4096 x 8 single-port array, physical index = {col[6:0], row[4:0]}.
//   - Power-up contents are all 0x00. Contents are NOT altered by reset.
// - Reset (reset_n=0, asynchronous)
//   - rd_data = 0, line_offset = 0, cur_col = 0, cur_row = 0, cursor_on = 0.
// - Write
//   - When we=1 on a posedge, mem[wr_addr] <= wr_data.
//   - The row is absolute: no scroll offset applied. No bounds check; all 4096 cells are writable.
// - Read
//   - Physical row = (rd_row + line_offset) mod 32; wraps within 5 bits.
//   - On a posedge with we=0: rd_data <= mem[{rd_col, phys_row}]. Latency is 1 clock.
// - Collision (single port, write has priority)
//   - On a cycle with we=1 the read is skipped and rd_data holds its previous value.
// - Registers
//   - off_we=1: line_offset <= off_in.
//   - cur_we=1: {cur_row, cur_col} <= cur_in.
//   - New values take effect on reads issued from the next cycle onward.
// - Cursor flag
//   - cursor_on <= (rd_col==cur_col) & (rd_row==cur_row) & blink.
//   - Compares the screen row (pre-offset). Updated every cycle, including write cycles, and aligned with rd_data.
// - Simultaneous events
//   - we, off_we and cur_we are independent; all may fire in the same cycle.
// TESTING
// - Reset: drive reset_n=0 mid-stream -> rd_data, line_offset, cur_col, cur_row, cursor_on read 0 immediately, with no clock edge needed.
// - Write/read: we=1, wr_addr=0x0A3 (col 5, row 3), wr_data=0x41; then rd_col=5, rd_row=3, we=0 -> rd_data=0x41 one clock later.
// - Scroll: off_in=2, write 0x42 at col 0 row 4; read rd_col=0, rd_row=2 -> 0x42.
//   - Wrap: off_in=31, read rd_row=1 -> returns the physical row 0 cell.
// - Collision: rd_data=0x41, then we=1 with any address -> rd_data stays 0x41. The next we=0 read returns the correct cell.
// - Cursor: cur_in=0x185 (row 3, col 5).
//   - Scan (5,3) with blink=1 -> cursor_on=1.
//   - blink=0 -> cursor_on=0.
//   - Scan (5,4) -> cursor_on=0.
// - Reset persistence: write 0x41 at (5,3), pulse reset_n low, read (5,3) with offset 0 -> 0x41.

Source files
------------

// File: rtl/char_buffer.sv
// Text-mode character store (128x32 cells) with vertical scroll offset and cursor-cell flag.
// Latency: rd_data and cursor_on are registered, one clock after rd_col/rd_row are presented.
// Backpressure: none; a write steals the single port and rd_data holds for that cycle.
module char_buffer #(
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   we,
    input  logic [COL_W+ROW_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [COL_W-1:0]       rd_col,
    input  logic [ROW_W-1:0]       rd_row,
    output logic [DATA_W-1:0]      rd_data,
    input  logic                   off_we,
    input  logic [ROW_W-1:0]       off_in,
    output logic [ROW_W-1:0]       line_offset,
    input  logic                   cur_we,
    input  logic [COL_W+ROW_W-1:0] cur_in,
    output logic [COL_W-1:0]       cur_col,
    output logic [ROW_W-1:0]       cur_row,
    input  logic                   blink,
    output logic                   cursor_on
);

    localparam int DEPTH = 1 << (COL_W + ROW_W);

    // Cell contents survive reset; only the power-up image is cleared.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic [ROW_W-1:0]       phys_row;
    logic [COL_W+ROW_W-1:0] rd_idx;
    logic                   cursor_hit;

    always_comb begin
        phys_row   = rd_row + line_offset;
        rd_idx     = {rd_col, phys_row};
        cursor_hit = (rd_col == cur_col) && (rd_row == cur_row) && blink;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (!we) begin
            rd_data <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_offset <= '0;
            cur_col     <= '0;
            cur_row     <= '0;
            cursor_on   <= 1'b0;
        end else begin
            if (off_we) begin
                line_offset <= off_in;
            end
            if (cur_we) begin
                {cur_row, cur_col} <= cur_in;
            end
            // Flag tracks the scan every cycle, so it stays aligned with rd_data even on write cycles.
            cursor_on <= cursor_hit;
        end
    end

endmodule

// File: tb/tb_char_buffer.sv
module tb_char_buffer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [6:0]  rd_col = '0;
    logic [4:0]  rd_row = '0;
    logic [7:0]  rd_data;
    logic        off_we = 1'b0;
    logic [4:0]  off_in = '0;
    logic [4:0]  line_offset;
    logic        cur_we = 1'b0;
    logic [11:0] cur_in = '0;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        blink = 1'b0;
    logic        cursor_on;

    char_buffer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_col      (rd_col),
        .rd_row      (rd_row),
        .rd_data     (rd_data),
        .off_we      (off_we),
        .off_in      (off_in),
        .line_offset (line_offset),
        .cur_we      (cur_we),
        .cur_in      (cur_in),
        .cur_col     (cur_col),
        .cur_row     (cur_row),
        .blink       (blink),
        .cursor_on   (cursor_on)
    );

    always #5 clk = ~clk;

    // Reference model: the screen as a plain 2-D array indexed [column][row].
    logic [7:0] scr [128][32];
    int         m_off;
    int         m_crow;
    int         m_ccol;
    logic [7:0] exp_rd;
    logic       exp_cur;

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        we     = 1'b0;
        off_we = 1'b0;
        cur_we = 1'b0;
    endtask

    task automatic model_reset();
        exp_rd  = 8'h00;
        exp_cur = 1'b0;
        m_off   = 0;
        m_crow  = 0;
        m_ccol  = 0;
    endtask

    // Predict one clock from the current inputs, advance, then compare all outputs.
    task automatic step();
        int col;
        int row;
        col = int'(rd_col);
        row = (int'(rd_row) + m_off) % 32;
        if (!we) exp_rd = scr[col][row];
        exp_cur = (int'(rd_col) == m_ccol) && (int'(rd_row) == m_crow) && blink;
        if (we) scr[int'(wr_addr) / 32][int'(wr_addr) % 32] = wr_data;
        if (off_we) m_off = int'(off_in);
        if (cur_we) begin
            m_crow = int'(cur_in) / 128;
            m_ccol = int'(cur_in) % 128;
        end
        @(posedge clk);
        #1;
        check("rd_data", 32'(rd_data), 32'(exp_rd));
        check("cursor_on", 32'(cursor_on), 32'(exp_cur));
        check("line_offset", 32'(line_offset), 32'(m_off));
        check("cur_col", 32'(cur_col), 32'(m_ccol));
        check("cur_row", 32'(cur_row), 32'(m_crow));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
        check({tag, "_line_offset"}, 32'(line_offset), 32'h0);
        check({tag, "_cur_col"}, 32'(cur_col), 32'h0);
        check({tag, "_cur_row"}, 32'(cur_row), 32'h0);
        check({tag, "_cursor_on"}, 32'(cursor_on), 32'h0);
    endtask

    initial begin
        for (int c = 0; c < 128; c++)
            for (int r = 0; r < 32; r++)
                scr[c][r] = 8'h00;
        model_reset();

        #12;
        check_reset_outputs("por");
        reset_n = 1'b1;

        // Basic write then read of (5,3).
        we = 1'b1; wr_addr = 12'h0A3; wr_data = 8'h41;
        step();
        idle(); rd_col = 7'd5; rd_row = 5'd3;
        step();
        check("wr_rd_41", 32'(rd_data), 32'h41);

        // Scroll by 2: screen row 2 shows physical row 4.
        off_we = 1'b1; off_in = 5'd2; we = 1'b1; wr_addr = 12'h004; wr_data = 8'h42;
        step();
        idle(); rd_col = 7'd0; rd_row = 5'd2;
        step();
        check("scroll_42", 32'(rd_data), 32'h42);

        // Offset 31: screen row 1 wraps to physical row 0.
        off_we = 1'b1; off_in = 5'd31; we = 1'b1; wr_addr = 12'h000; wr_data = 8'h55;
        step();
        idle(); rd_col = 7'd0; rd_row = 5'd1;
        step();
        check("wrap_55", 32'(rd_data), 32'h55);

        // Collision: a write cycle holds rd_data.
        off_we = 1'b1; off_in = 5'd0;
        step();
        idle(); rd_col = 7'd5; rd_row = 5'd3;
        step();
        check("pre_coll_41", 32'(rd_data), 32'h41);
        we = 1'b1; wr_addr = 12'h7FF; wr_data = 8'h99;
        step();
        check("coll_hold_41", 32'(rd_data), 32'h41);
        idle(); rd_col = 7'd63; rd_row = 5'd31;
        step();
        check("post_coll_99", 32'(rd_data), 32'h99);

        // Cursor at row 3, col 5.
        cur_we = 1'b1; cur_in = 12'h185;
        step();
        idle(); rd_col = 7'd5; rd_row = 5'd3; blink = 1'b1;
        step();
        check("cur_on", 32'(cursor_on), 32'h1);
        blink = 1'b0;
        step();
        check("cur_blink_off", 32'(cursor_on), 32'h0);
        blink = 1'b1; rd_row = 5'd4;
        step();
        check("cur_other_row", 32'(cursor_on), 32'h0);

        // Mid-stream asynchronous reset, then memory persistence.
        #3 reset_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_reset();
        #2 reset_n = 1'b1;
        blink = 1'b0; rd_col = 7'd5; rd_row = 5'd3;
        step();
        check("persist_41", 32'(rd_data), 32'h41);

        // Randomized traffic on a narrow window so reads, writes and cursor collide often.
        for (int i = 0; i < 1500; i++) begin
            we      = ($urandom_range(0, 3) == 0);
            wr_addr = 12'($urandom_range(0, 255));
            wr_data = 8'($urandom);
            rd_col  = 7'($urandom_range(0, 7));
            rd_row  = 5'($urandom_range(0, 31));
            off_we  = ($urandom_range(0, 9) == 0);
            off_in  = 5'($urandom);
            cur_we  = ($urandom_range(0, 9) == 0);
            cur_in  = {5'($urandom), 7'($urandom_range(0, 7))};
            blink   = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rd_col = 7'(m_ccol);
                rd_row = 5'(m_crow);
            end
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
